// File: rtl/ddmtd_nco.sv
// ddmtd_nco: numerically controlled oscillator closing the DDMTD loop.
// Turns the signed loop-filter correction into a clamped, slew-limited
// frequency control word, runs a phase accumulator whose MSB is the
// feedback clock, and tracks lock from consecutive small corrections.
module ddmtd_nco #(
  parameter int               ACC_W    = 16,
  parameter int               CTRL_W   = 24,
  parameter int               CTRL_SH  = 8,
  parameter logic [ACC_W-1:0] FCW_NOM  = 16'h0800,
  parameter logic [ACC_W-1:0] FCW_MIN  = 16'h0100,
  parameter logic [ACC_W-1:0] FCW_MAX  = 16'h2000,
  parameter logic [ACC_W-1:0] SLEW_MAX = 16'h0040,
  parameter logic [ACC_W-1:0] LOCK_TOL = 16'h0010,
  parameter int               LOCK_CNT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     ctrl_valid,
  input  logic signed [CTRL_W-1:0] ctrl,
  output logic                     clk_fb,
  output logic                     fb_edge,
  output logic [ACC_W-1:0]         cur_fcw,
  output logic                     sat,
  output logic                     locked
);

  // Width of the shifted correction, and of the overflow-free sum.
  localparam int DW    = CTRL_W - CTRL_SH;
  localparam int SW    = ACC_W + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } lock_state_t;

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_target;
  logic [ACC_W-1:0]  r_cur_fcw;
  logic              r_fb_edge;
  logic              r_sat;
  logic [CNT_W-1:0]  r_lock_cnt;
  lock_state_t       r_state;

  logic [CNT_W-1:0]  w_lock_cnt_next;
  lock_state_t       w_state_next;
  logic              w_update;
  logic signed [DW-1:0] w_delta;
  logic signed [SW-1:0] w_delta_x;
  logic signed [SW-1:0] w_sum;
  logic [SW-1:0]     w_delta_abs;
  logic              w_clamp_lo;
  logic              w_clamp_hi;
  logic              w_in_tol;
  logic [ACC_W-1:0]  w_target_next;
  logic              w_up;
  logic [ACC_W-1:0]  w_dist;
  logic [ACC_W-1:0]  w_cur_next;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_unused_lsbs;

  // Updates are only accepted while enabled; a strobe under ena=0 is lost.
  assign w_update = ena & ctrl_valid;

  // ctrl >>> CTRL_SH truncated to DW bits is exactly the upper field of ctrl;
  // the bits shifted out carry no information for the loop.
  assign w_delta       = ctrl[CTRL_W-1:CTRL_SH];
  assign w_unused_lsbs = ^ctrl[CTRL_SH-1:0];

  // Sign-extend and add to the nominal word in a width that cannot overflow.
  assign w_delta_x  = {{(SW-DW){w_delta[DW-1]}}, w_delta};
  assign w_sum      = $signed({2'b00, FCW_NOM}) + w_delta_x;
  assign w_clamp_lo = w_sum < $signed({2'b00, FCW_MIN});
  assign w_clamp_hi = w_sum > $signed({2'b00, FCW_MAX});
  assign w_target_next = w_clamp_hi ? FCW_MAX :
                         w_clamp_lo ? FCW_MIN : w_sum[ACC_W-1:0];

  // Magnitude is taken in the wide domain so the most negative delta is safe.
  assign w_delta_abs = w_delta_x[SW-1] ? -w_delta_x : w_delta_x;
  assign w_in_tol    = (w_delta_abs <= {2'b00, LOCK_TOL}) && !(w_clamp_lo || w_clamp_hi);

  // Slew toward the registered target, landing exactly on it when close.
  assign w_up       = r_target >= r_cur_fcw;
  assign w_dist     = w_up ? (r_target - r_cur_fcw) : (r_cur_fcw - r_target);
  assign w_cur_next = (w_dist <= SLEW_MAX) ? r_target :
                      w_up ? (r_cur_fcw + SLEW_MAX) : (r_cur_fcw - SLEW_MAX);

  assign w_acc_next = r_acc + r_cur_fcw;

  // Datapath registers: accumulator, slewed FCW, target, edge pulse, clamp flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_target  <= FCW_NOM;
      r_cur_fcw <= FCW_NOM;
      r_fb_edge <= 1'b0;
      r_sat     <= 1'b0;
    end else if (ena) begin
      r_acc     <= w_acc_next;
      r_cur_fcw <= w_cur_next;
      r_fb_edge <= ~r_acc[ACC_W-1] & w_acc_next[ACC_W-1];
      if (w_update) begin
        r_target <= w_target_next;
        r_sat    <= w_clamp_lo | w_clamp_hi;
      end
    end else begin
      r_fb_edge <= 1'b0;
    end
  end

  // Lock state and consecutive in-tolerance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_UNLOCKED;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lock_cnt <= w_lock_cnt_next;
    end
  end

  // Lock next-state: advances only on accepted updates, counter saturates.
  always_comb begin
    w_state_next    = r_state;
    w_lock_cnt_next = r_lock_cnt;
    if (w_update) begin
      if (w_in_tol) begin
        if (r_lock_cnt != CNT_W'(LOCK_CNT)) begin
          w_lock_cnt_next = r_lock_cnt + CNT_W'(1);
        end
        if (w_lock_cnt_next == CNT_W'(LOCK_CNT)) begin
          w_state_next = S_LOCKED;
        end
      end else begin
        w_lock_cnt_next = '0;
        w_state_next    = S_UNLOCKED;
      end
    end
  end

  assign clk_fb  = r_acc[ACC_W-1];
  assign fb_edge = r_fb_edge;
  assign cur_fcw = r_cur_fcw;
  assign sat     = r_sat;
  assign locked  = (r_state == S_LOCKED);

endmodule

// File: tb/tb_ddmtd_nco.sv
// tb_ddmtd_nco: directed, table-driven bench for the DDMTD NCO.
module tb_ddmtd_nco;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        ctrl_valid;
  logic [23:0] ctrl;
  logic        clk_fb;
  logic        fb_edge;
  logic [15:0] cur_fcw;
  logic        sat;
  logic        locked;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [23:0] ctrl;
    logic [15:0] exp_fcw;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[10];

  ddmtd_nco dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ctrl_valid (ctrl_valid),
    .ctrl       (ctrl),
    .clk_fb     (clk_fb),
    .fb_edge    (fb_edge),
    .cur_fcw    (cur_fcw),
    .sat        (sat),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [23:0] c);
    ctrl_valid = 1'b1;
    ctrl       = c;
    tick();
    ctrl_valid = 1'b0;
  endtask

  // Runaway guard; the directed sequence finishes far earlier.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int high;
    logic saved_fb;

    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    ena        = 1'b0;
    ctrl_valid = 1'b0;
    ctrl       = '0;

    vecs[0] = '{24'h000800, 16'h0808, 1'b0};
    vecs[1] = '{24'h7FFFFF, 16'h2000, 1'b1};
    vecs[2] = '{24'h800000, 16'h0100, 1'b1};
    vecs[3] = '{24'h000000, 16'h0800, 1'b0};
    vecs[4] = '{24'hFFF000, 16'h07F0, 1'b0};
    vecs[5] = '{24'h0F0000, 16'h1700, 1'b0};
    vecs[6] = '{24'h180000, 16'h2000, 1'b0};
    vecs[7] = '{24'hF90000, 16'h0100, 1'b0};
    vecs[8] = '{24'hF8FF00, 16'h0100, 1'b1};
    vecs[9] = '{24'h000000, 16'h0800, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_fcw",    32'(cur_fcw), 32'h0800);
    check("rst_clk_fb", 32'(clk_fb),  0);
    check("rst_fb_edge",32'(fb_edge), 0);
    check("rst_sat",    32'(sat),     0);
    check("rst_locked", 32'(locked),  0);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Free-running at nominal FCW: first edge on the 16th cycle, period 32
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        check("pre_edge_fb",    32'(fb_edge), 0);
        check("pre_edge_clkfb", 32'(clk_fb),  0);
      end
    end
    check("first_edge",  32'(fb_edge), 1);
    check("first_clkfb", 32'(clk_fb),  1);
    edges = 0;
    high  = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (clk_fb) high++;
      if (fb_edge && i < 32) edges++;
      if (i == 32) check("period_edge", 32'(fb_edge), 1);
    end
    check("spurious_edges", 32'(edges), 0);
    check("duty_high",      32'(high),  16);
    check("idle_fcw",       32'(cur_fcw), 32'h0800);

    // Table: one strobe, sat after 1 cycle, settled FCW after the ramp
    for (int v = 0; v < 10; v++) begin
      strobe(vecs[v].ctrl);
      check("tbl_sat", 32'(sat), 32'(vecs[v].exp_sat));
      repeat (130) tick();
      check("tbl_fcw", 32'(cur_fcw), 32'(vecs[v].exp_fcw));
      $display("[TB] vec %0d ctrl=0x%06h fcw=0x%04h sat=%0b", v, vecs[v].ctrl, cur_fcw, sat);
    end

    // Two-cycle latency from strobe to cur_fcw
    strobe(24'h000800);
    check("lat_hold", 32'(cur_fcw), 32'h0800);
    tick();
    check("lat_apply", 32'(cur_fcw), 32'h0808);

    // Ramp up, then redirect mid-ramp
    strobe(24'h000000);
    repeat (4) tick();
    check("ramp_base", 32'(cur_fcw), 32'h0800);
    strobe(24'h100000);
    check("ramp_lat", 32'(cur_fcw), 32'h0800);
    repeat (10) tick();
    check("ramp_10", 32'(cur_fcw), 32'h0A80);
    strobe(24'h000000);
    check("ramp_11", 32'(cur_fcw), 32'h0AC0);
    tick();
    check("ramp_reverse", 32'(cur_fcw), 32'h0A80);
    repeat (9) tick();
    check("ramp_down_9", 32'(cur_fcw), 32'h0840);
    tick();
    check("ramp_down_10", 32'(cur_fcw), 32'h0800);
    repeat (3) tick();
    check("no_overshoot", 32'(cur_fcw), 32'h0800);

    // Full ramp: 64 slew steps from 0x0800 to 0x1800
    strobe(24'h100000);
    repeat (63) tick();
    check("full_63", 32'(cur_fcw), 32'h17C0);
    tick();
    check("full_64", 32'(cur_fcw), 32'h1800);
    tick();
    check("full_hold", 32'(cur_fcw), 32'h1800);
    strobe(24'h000000);
    repeat (70) tick();

    // Lock: eight in-tolerance updates, ena gap with a dropped strobe
    strobe(24'h001100);
    tick();
    for (int n = 1; n <= 8; n++) begin
      strobe(24'h001000);
      if (n == 7) check("lock_7", 32'(locked), 0);
      if (n == 8) check("lock_8", 32'(locked), 1);
      if (n == 3) begin
        ena        = 1'b0;
        ctrl_valid = 1'b1;
        ctrl       = 24'h001000;
        repeat (3) tick();
        ctrl_valid = 1'b0;
        ena        = 1'b1;
      end else begin
        tick();
      end
    end
    strobe(24'h001100);
    check("unlock_tol", 32'(locked), 0);
    tick();
    for (int n = 1; n <= 8; n++) begin
      strobe(24'h001000);
      if (n == 7) check("relock_7", 32'(locked), 0);
      if (n == 8) check("relock_8", 32'(locked), 1);
      tick();
    end

    // Freeze mid-ramp with ena=0; strobes must be dropped
    strobe(24'h7FFFFF);
    check("frz_sat", 32'(sat), 1);
    check("frz_unlock", 32'(locked), 0);
    check("frz_start", 32'(cur_fcw), 32'h0810);
    repeat (5) tick();
    check("frz_pre", 32'(cur_fcw), 32'h0950);
    ena        = 1'b0;
    ctrl_valid = 1'b1;
    ctrl       = 24'h800000;
    saved_fb   = clk_fb;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_fcw",    32'(cur_fcw), 32'h0950);
      check("frz_edge",   32'(fb_edge), 0);
      check("frz_clk_fb", 32'(clk_fb),  32'(saved_fb));
    end
    ctrl_valid = 1'b0;
    ena        = 1'b1;
    tick();
    check("frz_resume", 32'(cur_fcw), 32'h0990);
    tick();
    tick();

    // Asynchronous reset mid-ramp, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fcw",    32'(cur_fcw), 32'h0800);
    check("arst_sat",    32'(sat),     0);
    check("arst_clk_fb", 32'(clk_fb),  0);
    check("arst_edge",   32'(fb_edge), 0);
    check("arst_locked", 32'(locked),  0);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    check("arst_target", 32'(cur_fcw), 32'h0800);
    check("arst_acc",    32'(clk_fb),  0);

    // Asynchronous reset while locked
    for (int n = 1; n <= 8; n++) begin
      strobe(24'h000000);
    end
    check("lock_pre_rst", 32'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_unlock", 32'(locked), 0);
    #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
